// File: rtl/mdu_pkg.sv
// Shared encodings for the iterative multiply/divide unit.
package mdu_pkg;

  localparam int XLEN_DEF  = 64;
  localparam int CNT_W_DEF = 7;

  typedef enum logic [1:0] {
    OP_MUL   = 2'b00,
    OP_MULHU = 2'b01,
    OP_DIVU  = 2'b10,
    OP_REMU  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_CALC = 2'b01,
    S_DONE = 2'b10
  } state_e;

endpackage

// File: rtl/mdu_div_step.sv
// One restoring-division step: shift in the next dividend bit, trial-subtract the divisor,
// and keep the difference only if it did not borrow.
module mdu_div_step #(
  parameter int XLEN = 64
) (
  input  logic [XLEN-1:0] i_rem,
  input  logic            i_dividend_msb,
  input  logic [XLEN-1:0] i_divisor,
  output logic [XLEN-1:0] o_rem_next,
  output logic            o_q_bit
);

  logic [XLEN:0]   w_shifted;
  logic [XLEN+1:0] w_diff;
  logic            w_borrow;
  logic            w_unused_diff_bit;

  assign w_shifted         = {i_rem, i_dividend_msb};
  assign w_diff            = {1'b0, w_shifted} - {2'b00, i_divisor};
  assign w_borrow          = w_diff[XLEN+1];
  // The remainder stays below the divisor, so bit XLEN of a non-borrowing difference is zero.
  assign w_unused_diff_bit = w_diff[XLEN];

  assign o_q_bit    = ~w_borrow;
  assign o_rem_next = w_borrow ? w_shifted[XLEN-1:0] : w_diff[XLEN-1:0];

endmodule

// File: rtl/mul_div_unit.sv
// Iterative unsigned multiply/divide unit: one shift-add or restoring-divide step per cycle,
// with the result handed to the register file as a one-cycle write.
//
//   state  | meaning
//   S_IDLE | waiting for start; operands, op and rd captured on acceptance
//   S_CALC | XLEN iterations, one per cycle
//   S_DONE | one cycle: done=1, Reg_Write=1 unless rd is x0
module mul_div_unit
  import mdu_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] Read_Data1,
  input  logic [XLEN-1:0] Read_Data2,
  input  logic [4:0]      rd_in,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] Write_Data,
  output logic [4:0]      rd,
  output logic            Reg_Write
);

  state_e          r_state;
  state_e          w_state_next;
  logic [CNT_W-1:0] r_cnt;
  op_e             r_op;
  logic [XLEN-1:0] r_opnd;
  logic [XLEN-1:0] r_hi;
  logic [XLEN-1:0] r_lo;
  logic [XLEN-1:0] r_wdata;
  logic [4:0]      r_rd_cap;
  logic [4:0]      r_rd;

  logic            w_accept;
  logic            w_is_div;
  logic            w_div_zero;
  logic            w_last;
  logic            w_calc_div;
  logic            w_sel_lo;
  logic            w_busy;
  logic            w_done;
  logic [XLEN:0]   w_mul_sum;
  logic [XLEN-1:0] w_mul_hi_next;
  logic [XLEN-1:0] w_mul_lo_next;
  logic [XLEN-1:0] w_rem_next;
  logic            w_q_bit;
  logic [XLEN-1:0] w_hi_next;
  logic [XLEN-1:0] w_lo_next;
  logic [XLEN-1:0] w_result;

  assign w_accept   = (r_state == S_IDLE) && start;
  assign w_is_div   = op[1];
  assign w_div_zero = w_is_div && (Read_Data2 == '0);
  assign w_last     = (r_cnt == CNT_W'(XLEN - 1));
  assign w_calc_div = (r_op == OP_DIVU) || (r_op == OP_REMU);
  assign w_sel_lo   = (r_op == OP_MUL) || (r_op == OP_DIVU);

  // Multiply: r_hi accumulates, r_lo holds the multiplier and shifts product bits in from the top.
  assign w_mul_sum     = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_opnd} : '0);
  assign w_mul_hi_next = w_mul_sum[XLEN:1];
  assign w_mul_lo_next = {w_mul_sum[0], r_lo[XLEN-1:1]};

  // Divide: r_hi is the partial remainder, r_lo shifts dividend bits out and quotient bits in.
  mdu_div_step #(.XLEN(XLEN)) u_div_step (
    .i_rem          (r_hi),
    .i_dividend_msb (r_lo[XLEN-1]),
    .i_divisor      (r_opnd),
    .o_rem_next     (w_rem_next),
    .o_q_bit        (w_q_bit)
  );

  assign w_hi_next = w_calc_div ? w_rem_next : w_mul_hi_next;
  assign w_lo_next = w_calc_div ? {r_lo[XLEN-2:0], w_q_bit} : w_mul_lo_next;
  assign w_result  = w_sel_lo ? w_lo_next : w_hi_next;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_busy       = 1'b1;
    w_done       = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_busy = 1'b0;
        if (start) begin
          w_state_next = w_div_zero ? S_DONE : S_CALC;
        end
      end
      S_CALC: begin
        if (w_last) begin
          w_state_next = S_DONE;
        end
      end
      S_DONE: begin
        w_done       = 1'b1;
        w_state_next = S_IDLE;
      end
      default: begin
        w_busy       = 1'b0;
        w_state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt    <= '0;
      r_op     <= OP_MUL;
      r_opnd   <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_rd_cap <= '0;
      r_wdata  <= '0;
      r_rd     <= '0;
    end else if (w_accept) begin
      r_cnt    <= '0;
      r_op     <= op_e'(op);
      r_rd_cap <= rd_in;
      r_hi     <= '0;
      r_opnd   <= w_is_div ? Read_Data2 : Read_Data1;
      r_lo     <= w_is_div ? Read_Data1 : Read_Data2;
      if (w_div_zero) begin
        r_wdata <= (op == OP_DIVU) ? '1 : Read_Data1;
        r_rd    <= rd_in;
      end
    end else if (r_state == S_CALC) begin
      r_cnt <= r_cnt + CNT_W'(1);
      r_hi  <= w_hi_next;
      r_lo  <= w_lo_next;
      if (w_last) begin
        r_wdata <= w_result;
        r_rd    <= r_rd_cap;
      end
    end
  end

  assign busy       = w_busy;
  assign done       = w_done;
  assign Write_Data = r_wdata;
  assign rd         = r_rd;
  assign Reg_Write  = w_done && (r_rd != 5'd0);

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed bench for mul_div_unit: a vector table of ops with hand-computed results,
// plus sequences for ignored starts, start held through DONE, and reset mid-calculation.
module tb_mul_div_unit;

  localparam int XLEN = 64;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic            start = 1'b0;
  logic [1:0]      op = 2'b00;
  logic [XLEN-1:0] Read_Data1 = '0;
  logic [XLEN-1:0] Read_Data2 = '0;
  logic [4:0]      rd_in = '0;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] Write_Data;
  logic [4:0]      rd;
  logic            Reg_Write;

  mul_div_unit #(.XLEN(XLEN), .CNT_W(7)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .op         (op),
    .Read_Data1 (Read_Data1),
    .Read_Data2 (Read_Data2),
    .rd_in      (rd_in),
    .busy       (busy),
    .done       (done),
    .Write_Data (Write_Data),
    .rd         (rd),
    .Reg_Write  (Reg_Write)
  );

  always #5 clk = ~clk;

  typedef struct {
    string           name;
    logic [1:0]      op;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic [4:0]      rd;
    logic [XLEN-1:0] exp;
    logic            exp_rw;
    int              exp_lat;
  } vec_t;

  int              n_tests = 0;
  int              n_fail  = 0;
  logic [XLEN-1:0] prev_wd = '0;
  vec_t            vecs[$];

  task automatic check(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input string name, input logic [1:0] o, input logic [XLEN-1:0] a,
                              input logic [XLEN-1:0] b, input logic [4:0] r,
                              input logic [XLEN-1:0] e, input int lat);
    vec_t v;
    v.name = name; v.op = o; v.a = a; v.b = b; v.rd = r; v.exp = e;
    v.exp_rw = (r != 5'd0); v.exp_lat = lat;
    return v;
  endfunction

  // Edges counted from the accepting edge (which counts as 1) until done is seen.
  task automatic wait_done(output int lat);
    lat = 1;
    while (!done && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic run_op(input vec_t v);
    int lat;
    @(negedge clk);
    op = v.op; Read_Data1 = v.a; Read_Data2 = v.b; rd_in = v.rd; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    Read_Data1 = ~v.a; Read_Data2 = v.b ^ 64'h5A5A_0000_0000_A5A5; rd_in = ~v.rd;
    check({v.name, " busy"}, 64'(busy), 64'd1);
    if (!done) check({v.name, " hold_prev"}, Write_Data, prev_wd);
    wait_done(lat);
    check({v.name, " latency"}, 64'(lat), 64'(v.exp_lat));
    check({v.name, " data"}, Write_Data, v.exp);
    check({v.name, " rd"}, 64'(rd), 64'(v.rd));
    check({v.name, " reg_write"}, 64'(Reg_Write), 64'(v.exp_rw));
    @(posedge clk); #1;
    check({v.name, " done_drop"}, 64'({done, Reg_Write, busy}), 64'd0);
    check({v.name, " data_hold"}, Write_Data, v.exp);
    prev_wd = v.exp;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int ndone;
    int nrw;
    int nbusy;
    logic [XLEN-1:0] first_wd;
    logic [4:0]      first_rd;

    vecs.push_back(mk("mul_7x6",     2'b00, 64'd7, 64'd6, 5'd3, 64'd42, 65));
    vecs.push_back(mk("mulhu_ones",  2'b01, '1, '1, 5'd4, 64'hFFFF_FFFF_FFFF_FFFE, 65));
    vecs.push_back(mk("mul_ones",    2'b00, '1, '1, 5'd5, 64'd1, 65));
    vecs.push_back(mk("divu_100_7",  2'b10, 64'd100, 64'd7, 5'd6, 64'd14, 65));
    vecs.push_back(mk("remu_100_7",  2'b11, 64'd100, 64'd7, 5'd7, 64'd2, 65));
    vecs.push_back(mk("divu_by0",    2'b10, 64'd5, 64'd0, 5'd8, 64'hFFFF_FFFF_FFFF_FFFF, 1));
    vecs.push_back(mk("remu_by0",    2'b11, 64'd5, 64'd0, 5'd9, 64'd5, 1));
    vecs.push_back(mk("mul_rd0",     2'b00, 64'd3, 64'd5, 5'd0, 64'd15, 65));
    vecs.push_back(mk("mulhu_2p65",  2'b01, 64'h8000_0000_0000_0000, 64'd4, 5'd1, 64'd2, 65));
    vecs.push_back(mk("divu_big",    2'b10, '1, 64'h10, 5'd2, 64'h0FFF_FFFF_FFFF_FFFF, 65));
    vecs.push_back(mk("remu_big",    2'b11, '1, 64'h10, 5'd31, 64'hF, 65));
    vecs.push_back(mk("divu_small",  2'b10, 64'd3, 64'd10, 5'd12, 64'd0, 65));
    vecs.push_back(mk("remu_small",  2'b11, 64'd3, 64'd10, 5'd13, 64'd3, 65));
    vecs.push_back(mk("mul_2p64",    2'b00, 64'h1_0000_0000, 64'h1_0000_0000, 5'd14, 64'd0, 65));
    vecs.push_back(mk("mulhu_2p64",  2'b01, 64'h1_0000_0000, 64'h1_0000_0000, 5'd15, 64'd1, 65));
    vecs.push_back(mk("divu_1_1",    2'b10, 64'd1, 64'd1, 5'd16, 64'd1, 65));

    #12;
    check("rst busy", 64'(busy), 64'd0);
    check("rst done", 64'(done), 64'd0);
    check("rst reg_write", 64'(Reg_Write), 64'd0);
    check("rst data", Write_Data, 64'd0);
    check("rst rd", 64'(rd), 64'd0);
    @(negedge clk);
    reset = 1'b1;

    foreach (vecs[i]) run_op(vecs[i]);

    // start pulsed mid-CALC with other operands must be ignored
    @(negedge clk);
    op = 2'b00; Read_Data1 = 64'd9; Read_Data2 = 64'd9; rd_in = 5'd10; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    ndone = 0; lat = 0; first_wd = '0; first_rd = '0;
    for (int e = 1; e <= 150; e++) begin
      if (e > 1) begin @(posedge clk); #1; end
      if (e == 10) begin
        start = 1'b1; op = 2'b10; Read_Data1 = 64'd1000; Read_Data2 = 64'd3; rd_in = 5'd11;
      end
      if (e == 12) start = 1'b0;
      if (done) begin
        ndone++;
        if (ndone == 1) begin lat = e; first_wd = Write_Data; first_rd = rd; end
      end
    end
    check("ignore ndone", 64'(ndone), 64'd1);
    check("ignore latency", 64'(lat), 64'd65);
    check("ignore data", first_wd, 64'd81);
    check("ignore rd", 64'(first_rd), 64'd10);

    // start held high through DONE is not taken until IDLE
    @(negedge clk);
    op = 2'b00; Read_Data1 = 64'd2; Read_Data2 = 64'd3; rd_in = 5'd12; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(lat);
    check("held data1", Write_Data, 64'd6);
    op = 2'b00; Read_Data1 = 64'd4; Read_Data2 = 64'd5; rd_in = 5'd13; start = 1'b1;
    @(posedge clk); #1;
    check("held idle", 64'({busy, done}), 64'd0);
    @(posedge clk); #1;
    start = 1'b0;
    check("held accept busy", 64'(busy), 64'd1);
    wait_done(lat);
    check("held latency", 64'(lat), 64'd65);
    check("held data2", Write_Data, 64'd20);
    check("held rd2", 64'(rd), 64'd13);
    @(posedge clk); #1;

    // reset in the middle of CALC
    @(negedge clk);
    op = 2'b00; Read_Data1 = 64'd3; Read_Data2 = 64'd5; rd_in = 5'd14; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (30) @(posedge clk);
    #2 reset = 1'b0;
    #1;
    check("abort busy", 64'(busy), 64'd0);
    check("abort done", 64'(done), 64'd0);
    check("abort reg_write", 64'(Reg_Write), 64'd0);
    check("abort data", Write_Data, 64'd0);
    check("abort rd", 64'(rd), 64'd0);
    @(negedge clk);
    reset = 1'b1;
    ndone = 0; nrw = 0; nbusy = 0;
    for (int c = 0; c < 100; c++) begin
      @(posedge clk); #1;
      if (done) ndone++;
      if (Reg_Write) nrw++;
      if (busy) nbusy++;
    end
    check("post_abort done", 64'(ndone), 64'd0);
    check("post_abort reg_write", 64'(nrw), 64'd0);
    check("post_abort busy", 64'(nbusy), 64'd0);
    prev_wd = '0;
    run_op(mk("mul_after_rst", 2'b00, 64'd7, 64'd6, 5'd3, 64'd42, 65));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
